activation_writeback_packer: RTL

Writer for the activation buffer's write port. Accepts a stream of signed MAC accumulator results, requantizes each to DATA_WIDTH (rounding shift, optional ReLU, saturation), packs four consecutive results into one buffer word, and issues sequential writes starting at a programmed base address. It sits between the MAC array output and the activation buffer, so one layer's results become the next layer's activations.

---
 rtl/activation_writeback_packer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/activation_writeback_packer.sv
// activation_writeback_packer
//   Requantizes a stream of signed MAC accumulator results (rounding shift,
//   optional ReLU, saturation to DATA_WIDTH), packs four consecutive results
//   into one activation buffer word and writes the words to sequential
//   addresses starting at a programmed base.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   start_i             : one-cycle job start (only honoured while idle)
//   base_addr_i         : first write address (latched on start)
//   word_count_i        : number of 4-lane words in the job (latched on start)
//   shift_i, relu_en_i  : requantization configuration (latched on start)
//   acc_valid_i/acc_data_i/acc_ready_o : accumulator result stream
//   buffer_wr_en_o/buffer_wr_addr_o/buffer_data_o : buffer write port
//   busy_o              : job in progress
//   done_o              : one-cycle pulse when the job finishes
module activation_writeback_packer #(
    parameter int DATA_WIDTH        = 7,
    parameter int MAC_ACC_WIDTH     = 48,
    parameter int BUFFER_ADDR_WIDTH = 15,
    parameter int SHIFT_WIDTH       = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic [BUFFER_ADDR_WIDTH-1:0]    base_addr_i,
    input  logic [BUFFER_ADDR_WIDTH:0]      word_count_i,
    input  logic [SHIFT_WIDTH-1:0]          shift_i,
    input  logic                            relu_en_i,
    input  logic                            acc_valid_i,
    input  logic signed [MAC_ACC_WIDTH-1:0] acc_data_i,
    output logic                            acc_ready_o,
    output logic                            buffer_wr_en_o,
    output logic [BUFFER_ADDR_WIDTH-1:0]    buffer_wr_addr_o,
    output logic [DATA_WIDTH*4-1:0]         buffer_data_o,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int LANES  = 4;
    localparam int WORD_W = DATA_WIDTH * LANES;
    localparam int EXT_W  = MAC_ACC_WIDTH + 1;
    localparam int CNT_W  = BUFFER_ADDR_WIDTH + 1;

    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Rounding arithmetic shift, optional ReLU and saturation of one result.
    function automatic logic [DATA_WIDTH-1:0] requantize(
        input logic signed [MAC_ACC_WIDTH-1:0] acc,
        input logic [SHIFT_WIDTH-1:0]          shift,
        input logic                            relu_en
    );
        logic [SHIFT_WIDTH-1:0]  eff_shift;
        logic signed [EXT_W-1:0] ext;
        logic signed [EXT_W-1:0] rounded;
        logic signed [EXT_W-1:0] shifted;
        logic [DATA_WIDTH-1:0]   result;
        // Every shift >= MAC_ACC_WIDTH already rounds all inputs to 0, so
        // clamping it keeps the rounding constant inside EXT_W bits.
        if (int'(shift) > MAC_ACC_WIDTH) begin
            eff_shift = SHIFT_WIDTH'(MAC_ACC_WIDTH);
        end else begin
            eff_shift = shift;
        end
        ext = {acc[MAC_ACC_WIDTH-1], acc};
        if (eff_shift != '0) begin
            rounded = ext + (EXT_W'(1'b1) << (eff_shift - SHIFT_WIDTH'(1)));
        end else begin
            rounded = ext;
        end
        shifted = rounded >>> eff_shift;
        if (relu_en && shifted[EXT_W-1]) begin
            result = '0;
        end else if (shifted > SAT_MAX) begin
            result = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            result = shifted[DATA_WIDTH-1:0];
        end
        return result;
    endfunction

    state_t                                 state_q, state_d;
    logic [1:0]                             lane_q, lane_d;
    logic [BUFFER_ADDR_WIDTH-1:0]           addr_q, addr_d;
    logic [CNT_W-1:0]                       remaining_q, remaining_d;
    logic [SHIFT_WIDTH-1:0]                 shift_q, shift_d;
    logic                                   relu_q, relu_d;
    logic [LANES-2:0][DATA_WIDTH-1:0]       lanes_q, lanes_d;
    logic                                   wr_en_q, wr_en_d;
    logic [BUFFER_ADDR_WIDTH-1:0]           wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]                      data_q, data_d;
    logic                                   done_q, done_d;
    logic                                   accept_s;
    logic [DATA_WIDTH-1:0]                  lane_val_s;

    assign accept_s   = acc_valid_i && (state_q == ST_RUN);
    assign lane_val_s = requantize(acc_data_i, shift_q, relu_q);

    // Next-state logic: job start, lane filling and word emission.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        lanes_d     = lanes_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        data_d      = data_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    addr_d      = base_addr_i;
                    remaining_d = word_count_i;
                    shift_d     = shift_i;
                    relu_d      = relu_en_i;
                    lane_d      = 2'd0;
                    // An empty job completes immediately without running.
                    if (word_count_i == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: lanes_d[0] = lane_val_s;
                        2'd1: lanes_d[1] = lane_val_s;
                        2'd2: lanes_d[2] = lane_val_s;
                        default: begin
                            // Fourth lane completes the word; it bypasses the
                            // lane register straight into the output word.
                            wr_en_d     = 1'b1;
                            wr_addr_d   = addr_q;
                            data_d      = {lane_val_s, lanes_q};
                            addr_d      = addr_q + BUFFER_ADDR_WIDTH'(1);
                            remaining_d = remaining_q - CNT_W'(1);
                            if (remaining_q == CNT_W'(1)) begin
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end
                    endcase
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lane_q      <= 2'd0;
            addr_q      <= '0;
            remaining_q <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            lanes_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            lanes_q     <= lanes_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
        end
    end

    assign acc_ready_o      = (state_q == ST_RUN);
    assign busy_o           = (state_q == ST_RUN);
    assign buffer_wr_en_o   = wr_en_q;
    assign buffer_wr_addr_o = wr_addr_q;
    assign buffer_data_o    = data_q;
    assign done_o           = done_q;

endmodule
